// File: rtl/ao21_mon_pkg.sv
// Shared types and readout word map for the AO21 activity monitor.
package ao21_mon_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARM   = 2'd1,
        ST_COUNT = 2'd2,
        ST_DRAIN = 2'd3
    } state_e;

    localparam int NUM_WORDS = 9;

    localparam logic [3:0] WORD_IN1_RISE = 4'd0;
    localparam logic [3:0] WORD_IN1_FALL = 4'd1;
    localparam logic [3:0] WORD_IN2_RISE = 4'd2;
    localparam logic [3:0] WORD_IN2_FALL = 4'd3;
    localparam logic [3:0] WORD_IN3_RISE = 4'd4;
    localparam logic [3:0] WORD_IN3_FALL = 4'd5;
    localparam logic [3:0] WORD_Q_RISE   = 4'd6;
    localparam logic [3:0] WORD_Q_FALL   = 4'd7;
    localparam logic [3:0] WORD_MISMATCH = 4'd8;
    localparam logic [3:0] LAST_WORD     = 4'(NUM_WORDS - 1);

endpackage

// File: rtl/ao21_edge_counter.sv
// One observed pin: previous-cycle baseline plus saturating rise and fall counters.
module ao21_edge_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             load_base,
    input  logic             enable,
    input  logic             pin,
    output logic [CNT_W-1:0] rise_cnt,
    output logic [CNT_W-1:0] fall_cnt
);

    logic             base_q, base_d;
    logic [CNT_W-1:0] rise_q, rise_d;
    logic [CNT_W-1:0] fall_q, fall_d;

    always_comb begin
        // NOTE: every next-state value defaults to hold first, so no path leaves one unassigned (no latch).
        base_d = base_q;
        rise_d = rise_q;
        fall_d = fall_q;
        if (clear) begin
            base_d = 1'b0;
            rise_d = '0;
            fall_d = '0;
        end else if (load_base) begin
            base_d = pin;
        end else if (enable) begin
            base_d = pin;
            if (!base_q && pin && (rise_q != '1)) rise_d = rise_q + 1'b1;
            if (base_q && !pin && (fall_q != '1)) fall_d = fall_q + 1'b1;
        end
    end

    // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            base_q <= 1'b0;
            rise_q <= '0;
            fall_q <= '0;
        end else begin
            base_q <= base_d;
            rise_q <= rise_d;
            fall_q <= fall_d;
        end
    end

    assign rise_cnt = rise_q;
    assign fall_cnt = fall_q;

endmodule

// File: rtl/ao21_activity_monitor.sv
// Counts pin transitions and AO21 logic mismatches over a window, then drains nine words.
module ao21_activity_monitor
    import ao21_mon_pkg::*;
#(
    parameter int CNT_W = 16,
    parameter int WIN_W = 16
) (
    input  logic             CLK,
    input  logic             RSTB,
    input  logic             START,
    input  logic [WIN_W-1:0] WINDOW,
    input  logic             IN1,
    input  logic             IN2,
    input  logic             IN3,
    input  logic             Q,
    output logic             BUSY,
    output logic             RD_VALID,
    input  logic             RD_READY,
    output logic [3:0]       RD_IDX,
    output logic [CNT_W-1:0] RD_DATA,
    output logic             DONE
);

    state_e           state_q, state_d;
    logic [WIN_W-1:0] win_q, win_d;
    logic [CNT_W-1:0] mis_q, mis_d;
    logic [3:0]       idx_q, idx_d;
    logic             done_q, done_d;

    logic             start_ok;
    logic             mismatch;
    logic [3:0]       pins;
    logic [CNT_W-1:0] rise_cnt [4];
    logic [CNT_W-1:0] fall_cnt [4];

    assign start_ok = (state_q == ST_IDLE) && START && (WINDOW != '0);
    assign mismatch = Q != (IN3 | (IN1 & IN2));
    assign pins     = {Q, IN3, IN2, IN1};

    for (genvar p = 0; p < 4; p++) begin : g_pin
        ao21_edge_counter #(.CNT_W(CNT_W)) u_edge (
            .clk      (CLK),
            .rst_n    (RSTB),
            .clear    (start_ok),
            .load_base(state_q == ST_ARM),
            .enable   (state_q == ST_COUNT),
            .pin      (pins[p]),
            .rise_cnt (rise_cnt[p]),
            .fall_cnt (fall_cnt[p])
        );
    end

    always_comb begin
        state_d = state_q;
        win_d   = win_q;
        mis_d   = mis_q;
        idx_d   = idx_q;
        done_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start_ok) begin
                    state_d = ST_ARM;
                    win_d   = WINDOW;
                    mis_d   = '0;
                end
            end
            ST_ARM: state_d = ST_COUNT;
            ST_COUNT: begin
                win_d = win_q - 1'b1;
                if (mismatch && (mis_q != '1)) mis_d = mis_q + 1'b1;
                // The sample taken in the final window cycle is counted before leaving.
                if (win_q == WIN_W'(1)) begin
                    state_d = ST_DRAIN;
                    idx_d   = '0;
                end
            end
            ST_DRAIN: begin
                if (RD_READY) begin
                    if (idx_q == LAST_WORD) begin
                        state_d = ST_IDLE;
                        idx_d   = '0;
                        done_d  = 1'b1;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RSTB) begin
        if (!RSTB) begin
            state_q <= ST_IDLE;
            win_q   <= '0;
            mis_q   <= '0;
            idx_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            win_q   <= win_d;
            mis_q   <= mis_d;
            idx_q   <= idx_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        RD_DATA = '0;
        if (state_q == ST_DRAIN) begin
            case (idx_q)
                WORD_IN1_RISE: RD_DATA = rise_cnt[0];
                WORD_IN1_FALL: RD_DATA = fall_cnt[0];
                WORD_IN2_RISE: RD_DATA = rise_cnt[1];
                WORD_IN2_FALL: RD_DATA = fall_cnt[1];
                WORD_IN3_RISE: RD_DATA = rise_cnt[2];
                WORD_IN3_FALL: RD_DATA = fall_cnt[2];
                WORD_Q_RISE:   RD_DATA = rise_cnt[3];
                WORD_Q_FALL:   RD_DATA = fall_cnt[3];
                WORD_MISMATCH: RD_DATA = mis_q;
                default:       RD_DATA = '0;
            endcase
        end
    end

    assign BUSY     = state_q != ST_IDLE;
    assign RD_VALID = state_q == ST_DRAIN;
    assign RD_IDX   = idx_q;
    assign DONE     = done_q;

endmodule

// File: tb/tb_ao21_activity_monitor.sv
// Scoreboard bench: a pin-level model predicts the nine readout words of every window.
module tb_ao21_activity_monitor;

    logic        clk = 1'b0;
    logic        rstb;
    logic        start_a, start_b;
    logic [15:0] window;
    logic        in1, in2, in3, q;
    logic        rd_ready;

    logic        busy_a, rv_a, done_a, busy_b, rv_b, done_b;
    logic [3:0]  ridx_a, ridx_b;
    logic [15:0] rdata_a;
    logic [3:0]  rdata_b;

    logic        use_b;
    logic        busy, rv, done;
    logic [3:0]  ridx;
    logic [15:0] rdata;

    int          n_tests = 0;
    int          n_fail  = 0;
    int unsigned exp_q[$];
    logic [3:0]  pat[$];   // per cycle {q, in3, in2, in1}; index 0 is the ARM cycle
    int          stall[9];

    always #5 clk = ~clk;

    ao21_activity_monitor #(.CNT_W(16), .WIN_W(16)) dut_a (
        .CLK(clk), .RSTB(rstb), .START(start_a), .WINDOW(window),
        .IN1(in1), .IN2(in2), .IN3(in3), .Q(q),
        .BUSY(busy_a), .RD_VALID(rv_a), .RD_READY(rd_ready),
        .RD_IDX(ridx_a), .RD_DATA(rdata_a), .DONE(done_a)
    );

    ao21_activity_monitor #(.CNT_W(4), .WIN_W(16)) dut_b (
        .CLK(clk), .RSTB(rstb), .START(start_b), .WINDOW(window),
        .IN1(in1), .IN2(in2), .IN3(in3), .Q(q),
        .BUSY(busy_b), .RD_VALID(rv_b), .RD_READY(rd_ready),
        .RD_IDX(ridx_b), .RD_DATA(rdata_b), .DONE(done_b)
    );

    assign busy  = use_b ? busy_b : busy_a;
    assign rv    = use_b ? rv_b : rv_a;
    assign done  = use_b ? done_b : done_a;
    assign ridx  = use_b ? ridx_b : ridx_a;
    assign rdata = use_b ? {12'b0, rdata_b} : rdata_a;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_start(input logic v);
        if (use_b) start_b = v;
        else start_a = v;
    endtask

    task automatic drive_pins(input logic [3:0] p);
        {q, in3, in2, in1} = p;
    endtask

    task automatic model_push(input int win, input int unsigned maxv);
        int unsigned w[9];
        logic [3:0]  prev, cur;
        for (int i = 0; i < 9; i++) w[i] = 0;
        for (int k = 1; k <= win; k++) begin
            prev = pat[k-1];
            cur  = pat[k];
            for (int p = 0; p < 4; p++) begin
                if (!prev[p] && cur[p] && w[2*p] < maxv) w[2*p]++;
                if (prev[p] && !cur[p] && w[2*p+1] < maxv) w[2*p+1]++;
            end
            if ((cur[3] != (cur[2] | (cur[0] & cur[1]))) && w[8] < maxv) w[8]++;
        end
        for (int i = 0; i < 9; i++) exp_q.push_back(w[i]);
    endtask

    // Runs one full window from pat[], optionally issuing a stray START in COUNT cycle inject_at.
    task automatic run_window(input int win, input int unsigned maxv, input int inject_at);
        int unsigned e;
        tick();
        set_start(1'b1);
        window = 16'(win);
        tick();
        set_start(1'b0);
        window = 16'd0;
        drive_pins(pat[0]);
        rd_ready = 1'b1;
        @(negedge clk);
        check("arm_busy", 32'(busy), 32'd1);
        for (int k = 1; k <= win; k++) begin
            tick();
            drive_pins(pat[k]);
            if (k == inject_at) begin
                set_start(1'b1);
                window = 16'd3;
            end else begin
                set_start(1'b0);
            end
        end
        @(negedge clk);
        check("count_no_valid", 32'(rv), 32'd0);
        model_push(win, maxv);
        tick();
        set_start(1'b0);
        for (int i = 0; i < 9; i++) begin
            for (int s = 0; s < stall[i]; s++) begin
                rd_ready = 1'b0;
                drive_pins(4'($urandom));
                @(negedge clk);
                check($sformatf("stall%0d_idx", i), 32'(ridx), 32'(i));
                check($sformatf("stall%0d_data", i), 32'(rdata), exp_q[0]);
                tick();
            end
            rd_ready = 1'b1;
            drive_pins(4'($urandom));
            @(negedge clk);
            e = exp_q.pop_front();
            check($sformatf("word%0d_valid", i), 32'(rv), 32'd1);
            check($sformatf("word%0d_idx", i), 32'(ridx), 32'(i));
            check($sformatf("word%0d_data", i), 32'(rdata), e);
            tick();
        end
        rd_ready = 1'b0;
        @(negedge clk);
        check("done_pulse", 32'(done), 32'd1);
        check("done_idle", 32'(busy), 32'd0);
        check("done_no_valid", 32'(rv), 32'd0);
        tick();
        @(negedge clk);
        check("done_single", 32'(done), 32'd0);
    endtask

    initial begin
        int saw;
        rstb = 1'b0;
        start_a = 1'b0;
        start_b = 1'b0;
        window = 16'd0;
        rd_ready = 1'b0;
        use_b = 1'b0;
        drive_pins(4'd0);
        for (int i = 0; i < 9; i++) stall[i] = 0;

        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_busy", 32'(busy_a), 32'd0);
        check("rst_valid", 32'(rv_a), 32'd0);
        check("rst_done", 32'(done_a), 32'd0);
        check("rst_idx", 32'(ridx_a), 32'd0);
        check("rst_data", 32'(rdata_a), 32'd0);
        @(posedge clk);
        #1 rstb = 1'b1;

        // IN1 toggling every cycle over an 8-cycle window
        pat.delete();
        for (int k = 0; k <= 8; k++) pat.push_back({3'b000, 1'(k % 2)});
        run_window(8, 32'hFFFF, 0);

        // IN3 high with Q low: mismatch every cycle
        pat.delete();
        for (int k = 0; k <= 4; k++) pat.push_back(4'b0100);
        run_window(4, 32'hFFFF, 0);

        // START with WINDOW=0 in IDLE is ignored
        tick();
        start_a = 1'b1;
        window = 16'd0;
        tick();
        start_a = 1'b0;
        @(negedge clk);
        check("zero_window_ignored", 32'(busy_a), 32'd0);

        // Random pins, stray START in COUNT, consumer stall on word 2
        pat.delete();
        for (int k = 0; k <= 12; k++) pat.push_back(4'($urandom));
        stall[2] = 3;
        run_window(12, 32'hFFFF, 2);
        stall[2] = 0;

        // Narrow counters saturate: IN3 and Q toggle together
        use_b = 1'b1;
        pat.delete();
        for (int k = 0; k <= 40; k++) pat.push_back({1'(k % 2), 1'(k % 2), 2'b00});
        run_window(40, 32'd15, 0);
        use_b = 1'b0;

        // Reset during COUNT cycle 3 of a 10-cycle window
        tick();
        start_a = 1'b1;
        window = 16'd10;
        tick();
        start_a = 1'b0;
        drive_pins(4'b0001);
        for (int k = 1; k <= 3; k++) begin
            tick();
            drive_pins(4'(k));
        end
        #2 rstb = 1'b0;
        @(negedge clk);
        check("abort_busy", 32'(busy_a), 32'd0);
        check("abort_valid", 32'(rv_a), 32'd0);
        tick();
        rstb = 1'b1;
        rd_ready = 1'b1;
        saw = 0;
        for (int c = 0; c < 15; c++) begin
            @(negedge clk);
            if (rv_a || done_a || busy_a) saw = 1;
        end
        check("abort_quiet", 32'(saw), 32'd0);
        rd_ready = 1'b0;

        // Normal run after the aborted window
        pat.delete();
        for (int k = 0; k <= 5; k++) pat.push_back(4'($urandom));
        run_window(5, 32'hFFFF, 0);

        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/ao21_activity_monitor.md
AO21_ACTIVITY_MONITOR -- requirements
Module: ao21_activity_monitor

Interface
REQ-001 Parameter CNT_W, default 16: width of every activity counter and of RD_DATA.
REQ-002 Parameter WIN_W, default 16: width of WINDOW.
REQ-003 Clock: one clock, CLK; reset: asynchronous, active-low, RSTB.
REQ-004 CLK  input  1  sole clock; all state updates on rising edge.
REQ-005 RSTB  input  1  asynchronous active-low reset.
REQ-006 START  input  1  single-cycle request to begin an observation window.
REQ-007 WINDOW  input  WIN_W  number of COUNT cycles; sampled only when START is accepted.
REQ-008 IN1, IN2, IN3  input  1 each  observed AO21 cell inputs, synchronous to CLK.
REQ-009 Q  input  1  observed AO21 cell output, synchronous to CLK.
REQ-010 BUSY  output  1  high whenever state is not IDLE.
REQ-011 RD_VALID  output  1  readout word valid.
REQ-012 RD_READY  input  1  consumer accepts the word when RD_VALID and RD_READY are both high.
REQ-013 RD_IDX  output  4  word index, 0..8.
REQ-014 RD_DATA  output  CNT_W  word value.
REQ-015 DONE  output  1  one-cycle pulse after word 8 is accepted.

Function
REQ-016 States: IDLE, ARM, COUNT, DRAIN.
REQ-017 IDLE: START with WINDOW != 0 -> ARM, capture WINDOW, clear all counters; START with WINDOW == 0 ignored; START in any other state ignored.
REQ-018 ARM: lasts exactly one cycle; registers IN1, IN2, IN3, Q as baseline; no counting -> COUNT.
REQ-019 COUNT: lasts exactly WINDOW cycles; each cycle compares current pin values with previous-cycle values; 0->1 increments that pin's rise counter, 1->0 its fall counter.
REQ-020 COUNT: each cycle with Q != (IN3 | (IN1 & IN2)) increments the mismatch counter.
REQ-021 All counters saturate at 2^CNT_W-1; no wrap-around.
REQ-022 Last COUNT cycle -> DRAIN; its sample is counted.
REQ-023 Word map: 0/1 IN1 rise/fall, 2/3 IN2 rise/fall, 4/5 IN3 rise/fall, 6/7 Q rise/fall, 8 mismatch.
REQ-024 DRAIN: RD_VALID high; RD_IDX starts at 0; advances by one per handshake; RD_IDX/RD_DATA stable while RD_VALID high and RD_READY low.
REQ-025 Handshake on word 8 -> IDLE, RD_VALID low, DONE high for that next cycle only.
REQ-026 Timing: START accepted in cycle 0 -> ARM in cycle 1 -> COUNT cycles 2..WINDOW+1 -> first RD_VALID in cycle WINDOW+2.
REQ-027 RD_READY held high: DRAIN lasts exactly 9 cycles.
REQ-028 Pin inputs and RD_READY ignored outside their states; counters hold their values until the next ARM.

Reset
REQ-029 RSTB low: state IDLE, counters, baseline and window counter 0; BUSY, RD_VALID, DONE, RD_IDX, RD_DATA all 0.
REQ-030 Reset mid-ARM/COUNT/DRAIN aborts immediately; no DONE; no further readout.
REQ-031 Release of RSTB takes effect synchronously; first START accepted on the first rising edge with RSTB high.

Structure
REQ-032 Package ao21_mon_pkg holds: state enum, word-index constants, NUM_WORDS = 9.
REQ-033 Sub-module ao21_edge_counter: per-pin baseline register plus saturating rise/fall counters; enable and clear inputs; instantiated four times.
REQ-034 Mismatch counter, window down-counter, FSM and readout mux live in the top level.

Verification
REQ-035 WINDOW=8, IN1 toggles every cycle, IN2=IN3=0, Q=0 -> words 0/1 = 4/4, all others 0, DONE in cycle 19 with RD_READY high.
REQ-036 WINDOW=4, IN3 held 1, Q held 0 -> word 8 = 4, words 0..7 = 0.
REQ-037 CNT_W=4, WINDOW=40, Q toggles every cycle with matching stimulus -> words 6/7 saturate at 15.
REQ-038 RD_READY low 3 cycles on word 2 -> RD_IDX=2 and RD_DATA stable all 3 cycles; no word skipped.
REQ-039 RSTB pulsed low during COUNT cycle 3 of WINDOW=10 -> BUSY=0 next cycle, no RD_VALID, no DONE; new START runs normally.
REQ-040 START during COUNT and START with WINDOW=0 in IDLE -> both ignored; counts of active window unchanged.
